// File: rtl/uart_line_receiver.sv
// Purpose: assembles bytes from the uart_rx core into CR/LF-terminated lines and drains each line as a byte stream.
// Latency: first line byte is presented one cycle after the terminator is accepted; a full line drains in line_len cycles.
// Backpressure: out_ready stalls the drain with out_data/out_last held; rx_data_ready is low while draining, so rx bytes are dropped.
// Optional: define LINE_RX_BACKSPACE_EN to make 0x08/0x7F erase the last stored byte instead of being stored.
module uart_line_receiver #(
    parameter int MAX_PAYLOAD = 32,
    parameter int LEN_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_valid,
    output logic             rx_data_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [LEN_W-1:0] line_len,
    output logic             line_overflow
);

    localparam int              IDX_W   = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_PAYLOAD);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    typedef enum logic {
        ST_COLLECT,
        ST_DRAIN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] wr_cnt;
    logic [LEN_W-1:0] rd_ptr;
    logic             ovf;
    logic [7:0]       line_buf [MAX_PAYLOAD];

    logic             is_term;
    logic             is_bs;
    logic             accept;
    logic             has_room;

    assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign has_room = (wr_cnt < MAX_CNT);

`ifdef LINE_RX_BACKSPACE_EN
    assign is_bs = (rx_data == 8'h08) || (rx_data == 8'h7F);
`else
    assign is_bs = 1'b0;
`endif

    // State register; reset abandons any line being drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode; outputs depend only on registered state.
    always_comb begin
        state_nxt     = state;
        rx_data_ready = 1'b0;
        accept        = 1'b0;
        out_valid     = 1'b0;
        out_last      = 1'b0;
        out_data      = 8'h00;
        case (state)
            ST_COLLECT: begin
                rx_data_ready = 1'b1;
                accept        = rx_data_valid;
                // Terminators on an empty line are swallowed, so CR LF yields one line.
                if (accept && is_term && (wr_cnt != '0)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_data  = line_buf[rd_ptr[IDX_W-1:0]];
                out_last  = (rd_ptr == (line_len - ONE));
                if (out_ready && out_last) begin
                    state_nxt = ST_COLLECT;
                end
            end
            default: begin
                state_nxt = ST_COLLECT;
            end
        endcase
    end

    // Counters, overflow flag and the line descriptor latched at the terminator.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt        <= '0;
            rd_ptr        <= '0;
            ovf           <= 1'b0;
            line_len      <= '0;
            line_overflow <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        if (is_term) begin
                            if (wr_cnt != '0) begin
                                line_len      <= wr_cnt;
                                line_overflow <= ovf;
                                rd_ptr        <= '0;
                            end
                        end else if (is_bs) begin
                            // Backspace erases a stored byte but never clears ovf.
                            if (wr_cnt != '0) begin
                                wr_cnt <= wr_cnt - ONE;
                            end
                        end else if (has_room) begin
                            wr_cnt <= wr_cnt + ONE;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            wr_cnt <= '0;
                            ovf    <= 1'b0;
                        end else begin
                            rd_ptr <= rd_ptr + ONE;
                        end
                    end
                end
                default: begin
                    wr_cnt <= '0;
                end
            endcase
        end
    end

    // Line storage; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if ((state == ST_COLLECT) && accept && !is_term && !is_bs && has_room) begin
            line_buf[wr_cnt[IDX_W-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_line_receiver.sv
// Self-checking bench for uart_line_receiver: directed lines, expected bytes queued by the stimulus,
// compared by an independent monitor whenever a byte is handed over.
// Drives on the falling edge; the monitor samples 3 time units after the falling edge.
module tb_uart_line_receiver;

    localparam int MAX_PAYLOAD = 32;
    localparam int LEN_W       = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_data_valid = 1'b0;
    logic             rx_data_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_last;
    logic [LEN_W-1:0] line_len;
    logic             line_overflow;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         len;
        logic       o;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    uart_line_receiver #(
        .MAX_PAYLOAD(MAX_PAYLOAD),
        .LEN_W      (LEN_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .line_len     (line_len),
        .line_overflow(line_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic l, input int len, input logic o);
        exp_t e;
        e.d = d; e.l = l; e.len = len; e.o = o;
        exp_q.push_back(e);
    endtask

    task automatic expect_str(input string s, input logic o);
        for (int i = 0; i < s.len(); i++) begin
            expect_byte(s[i], (i == s.len() - 1), s.len(), o);
        end
    endtask

    // Waits for the receiver to be ready, then pulses one byte; returns on the next falling edge.
    task automatic send(input logic [7:0] b);
        int cnt;
        @(negedge clk);
        cnt = 0;
        while (!rx_data_ready && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 300) bound_expired("send_ready");
        rx_data       = b;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
        rx_data       = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while ((out_valid || exp_q.size() != 0) && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 300) bound_expired("wait_idle");
        @(negedge clk);
    endtask

    // Monitor: every handed-over byte must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got 0x%0h expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_last", out_last, e.l);
                    check("line_len", line_len, e.len);
                    check("line_overflow", line_overflow, e.o);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_rx_ready", rx_data_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_line_len", line_len, 0);
        check("rst_line_ovf", line_overflow, 0);

        // "abc" CR: latency 1, back-to-back drain, then ready again.
        expect_str("abc", 1'b0);
        send_str("abc");
        send(8'h0D);
        check("lat1_valid", out_valid, 1);
        check("lat1_data", out_data, 8'h61);
        check("drain_rx_ready", rx_data_ready, 0);
        @(negedge clk);
        check("b2b_valid1", out_valid, 1);
        @(negedge clk);
        check("b2b_valid2_last", {out_valid, out_last}, 2'b11);
        @(negedge clk);
        check("post_line_valid", out_valid, 0);
        check("post_line_ready", rx_data_ready, 1);
        wait_idle();

        // Empty terminators produce nothing; then "Z" LF.
        send(8'h0D);
        send(8'h0A);
        send(8'h0A);
        @(negedge clk);
        check("empty_no_valid", out_valid, 0);
        expect_str("Z", 1'b0);
        send(8'h5A);
        send(8'h0A);
        wait_idle();

        // Overflow: 40 x 'A' keeps 32 bytes and flags the loss.
        for (int i = 0; i < MAX_PAYLOAD; i++) expect_byte(8'h41, (i == MAX_PAYLOAD - 1), MAX_PAYLOAD, 1'b1);
        for (int i = 0; i < 40; i++) send(8'h41);
        send(8'h0D);
        wait_idle();
        expect_str("B", 1'b0);
        send_str("B");
        send(8'h0D);
        wait_idle();

        // Stall on byte 2 of "hello" for 5 cycles.
        expect_str("hello", 1'b0);
        send_str("hello");
        send(8'h0D);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", {out_valid, out_last, rx_data_ready, out_data}, {1'b1, 1'b0, 1'b0, 8'h6C});
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_idle();

        // Reset in the middle of a drain abandons the line.
        out_ready = 1'b0;
        send_str("abcdef");
        send(8'h0D);
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", rx_data_ready, 1);
        check("midrst_len", line_len, 0);
        out_ready = 1'b1;
        expect_str("x", 1'b0);
        send_str("x");
        send(8'h0D);
        wait_idle();

        // Backspace handling depends on the build.
`ifdef LINE_RX_BACKSPACE_EN
        expect_str("ac", 1'b0);
`else
        expect_byte(8'h61, 1'b0, 4, 1'b0);
        expect_byte(8'h62, 1'b0, 4, 1'b0);
        expect_byte(8'h08, 1'b0, 4, 1'b0);
        expect_byte(8'h63, 1'b1, 4, 1'b0);
`endif
        send_str("ab");
        send(8'h08);
        send_str("c");
        send(8'h0D);
        wait_idle();

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
